// File: rtl/bt1120_timing_ctrl_if.sv
// rtl/bt1120_timing_ctrl_if.sv - configuration handshake and timing bus for bt1120_timing_ctrl
interface bt1120_timing_ctrl_if #(
    parameter int VH_BITWIDTH = 13
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [VH_BITWIDTH-1:0] cfg_h_total;
    logic [VH_BITWIDTH-1:0] cfg_v_total;
    logic [3:0]             cfg_ce_div;
    logic                   cfg_err;
    logic [VH_BITWIDTH-1:0] h_total;
    logic [VH_BITWIDTH-1:0] v_total;
    logic                   ce;
    logic [VH_BITWIDTH-1:0] h_cnt;
    logic [VH_BITWIDTH-1:0] v_cnt;
    logic                   frame_start;

    modport master (
        output cfg_valid, cfg_h_total, cfg_v_total, cfg_ce_div,
        input  cfg_ready, cfg_err, h_total, v_total, ce, h_cnt, v_cnt, frame_start
    );

    modport slave (
        input  cfg_valid, cfg_h_total, cfg_v_total, cfg_ce_div,
        output cfg_ready, cfg_err, h_total, v_total, ce, h_cnt, v_cnt, frame_start
    );
endinterface

// File: rtl/bt1120_timing_ctrl.sv
// rtl/bt1120_timing_ctrl.sv - IDLE/ARM/RUN frame timing controller with pending-config handoff
module bt1120_timing_ctrl #(
    parameter int VH_BITWIDTH = 13,
    parameter int SETTLE      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    bt1120_timing_ctrl_if.slave    bus
);
    localparam int W  = VH_BITWIDTH;
    localparam int AW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t         state;
    logic [AW-1:0]  arm_cnt;
    logic [3:0]     div_cnt;
    logic [3:0]     ce_div;
    logic [W-1:0]   h_total_r, v_total_r, h_cnt_r, v_cnt_r;
    logic [W-1:0]   pend_h, pend_v;
    logic [3:0]     pend_div;
    logic           pending, stop_req, cfg_err_r;

    logic xfer, cfg_ok, load_now, ce_i, h_last, v_last, frame_end;

    assign bus.cfg_ready = (state != RUN) || !pending;
    assign xfer      = bus.cfg_valid && bus.cfg_ready;
    assign cfg_ok    = (bus.cfg_h_total >= W'(2)) && (bus.cfg_v_total >= W'(2));
    assign load_now  = xfer && cfg_ok;
    assign ce_i      = (state == RUN) && (div_cnt == 4'd0);
    assign h_last    = (h_cnt_r == h_total_r - W'(1));
    assign v_last    = (v_cnt_r == v_total_r - W'(1));
    assign frame_end = ce_i && h_last && v_last;

    assign busy            = (state != IDLE);
    assign bus.cfg_err     = cfg_err_r;
    assign bus.h_total     = h_total_r;
    assign bus.v_total     = v_total_r;
    assign bus.ce          = ce_i;
    assign bus.h_cnt       = h_cnt_r;
    assign bus.v_cnt       = v_cnt_r;
    assign bus.frame_start = ce_i && (h_cnt_r == '0) && (v_cnt_r == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            arm_cnt   <= '0;
            div_cnt   <= '0;
            ce_div    <= '0;
            h_total_r <= '0;
            v_total_r <= '0;
            h_cnt_r   <= '0;
            v_cnt_r   <= '0;
            pend_h    <= '0;
            pend_v    <= '0;
            pend_div  <= '0;
            pending   <= 1'b0;
            stop_req  <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= xfer && !cfg_ok;
            // Outside RUN no frame is in flight, so a good config goes live at once.
            if (load_now && state != RUN) begin
                h_total_r <= bus.cfg_h_total;
                v_total_r <= bus.cfg_v_total;
                ce_div    <= bus.cfg_ce_div;
            end
            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    if (start && !stop && h_total_r != '0) begin
                        state   <= ARM;
                        arm_cnt <= '0;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (arm_cnt == AW'(SETTLE - 1)) begin
                        state <= RUN;
                    end else begin
                        arm_cnt <= arm_cnt + AW'(1);
                    end
                end
                RUN: begin
                    if (stop) stop_req <= 1'b1;
                    if (load_now) begin
                        pending  <= 1'b1;
                        pend_h   <= bus.cfg_h_total;
                        pend_v   <= bus.cfg_v_total;
                        pend_div <= bus.cfg_ce_div;
                    end
                    div_cnt <= (div_cnt >= ce_div) ? 4'd0 : div_cnt + 4'd1;
                    if (ce_i) begin
                        if (h_last) begin
                            h_cnt_r <= '0;
                            v_cnt_r <= v_last ? '0 : v_cnt_r + W'(1);
                        end else begin
                            h_cnt_r <= h_cnt_r + W'(1);
                        end
                    end
                    if (frame_end) begin
                        if (pending) begin
                            h_total_r <= pend_h;
                            v_total_r <= pend_v;
                            ce_div    <= pend_div;
                            pending   <= 1'b0;
                            div_cnt   <= 4'd0;
                        end
                        // A config offered on the final ce of a stopping frame must not be stranded in pending.
                        if (stop_req || stop) begin
                            state    <= IDLE;
                            stop_req <= 1'b0;
                            div_cnt  <= 4'd0;
                            if (load_now) begin
                                h_total_r <= bus.cfg_h_total;
                                v_total_r <= bus.cfg_v_total;
                                ce_div    <= bus.cfg_ce_div;
                                pending   <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bt1120_timing_ctrl.sv
// tb/tb_bt1120_timing_ctrl.sv - scoreboard bench for bt1120_timing_ctrl
module tb_bt1120_timing_ctrl;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic busy;

    bt1120_timing_ctrl_if #(.VH_BITWIDTH(W)) bus ();

    bt1120_timing_ctrl #(.VH_BITWIDTH(W), .SETTLE(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int fs;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ce and checks ce spacing and counter stability.
    int cyc = 0;
    int last_ce_cyc = 0;
    logic prev_ce = 1'b0;
    int prev_h = 0;
    int prev_v = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.ce) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ce", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("h_cnt", int'(bus.h_cnt), e.h);
                check("v_cnt", int'(bus.v_cnt), e.v);
                check("frame_start", int'(bus.frame_start), e.fs);
                if (e.gap != 0) check("ce_gap", cyc - last_ce_cyc, e.gap);
            end
            last_ce_cyc = cyc;
        end
        if (!rst && busy && !prev_ce) begin
            check("h_hold_no_ce", int'(bus.h_cnt), prev_h);
            check("v_hold_no_ce", int'(bus.v_cnt), prev_v);
        end
        prev_ce = bus.ce;
        prev_h  = int'(bus.h_cnt);
        prev_v  = int'(bus.v_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int h, input int v, input int gap_first, input int gap);
        exp_t e;
        for (int vi = 0; vi < v; vi++) begin
            for (int hi = 0; hi < h; hi++) begin
                e.h   = hi;
                e.v   = vi;
                e.fs  = (hi == 0 && vi == 0) ? 1 : 0;
                e.gap = (hi == 0 && vi == 0) ? gap_first : gap;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_cfg(input int h, input int v, input int d);
        bit ok = 1'b0;
        bus.cfg_valid   = 1'b1;
        bus.cfg_h_total = W'(h);
        bus.cfg_v_total = W'(v);
        bus.cfg_ce_div  = 4'(d);
        for (int i = 0; i < 400; i++) begin
            if (bus.cfg_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        if (!ok) check("cfg_accept_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_hv(input int h, input int v);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (busy && int'(bus.h_cnt) == h && int'(bus.v_cnt) == v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("wait_hv_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bus.cfg_valid   = 1'b0;
        bus.cfg_h_total = '0;
        bus.cfg_v_total = '0;
        bus.cfg_ce_div  = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state, start with zero totals ignored
        check("rst_busy", int'(busy), 0);
        check("rst_ce", int'(bus.ce), 0);
        check("rst_h_total", int'(bus.h_total), 0);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        pulse_start();
        check("start_zero_cfg_busy", int'(busy), 0);

        // Valid config in IDLE, then invalid one rejected
        send_cfg(8, 4, 0);
        check("cfg_h_total", int'(bus.h_total), 8);
        check("cfg_v_total", int'(bus.v_total), 4);
        check("cfg_err_clean", int'(bus.cfg_err), 0);
        send_cfg(1, 4, 0);
        check("cfg_err_pulse", int'(bus.cfg_err), 1);
        check("bad_cfg_h_kept", int'(bus.h_total), 8);
        tick();
        check("cfg_err_one_cycle", int'(bus.cfg_err), 0);

        // 8/4/0: ARM latency, two frames, stop at h=3 v=1 of second frame
        push_frame(8, 4, 0, 1);
        push_frame(8, 4, 1, 1);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("arm_busy", int'(busy), 1);
            check("arm_ce", int'(bus.ce), 0);
            tick();
        end
        check("run_ce", int'(bus.ce), 1);
        wait_hv(3, 1);
        wait_hv(0, 0);
        wait_hv(3, 1);
        pulse_stop();
        drain();
        check("stop_busy", int'(busy), 0);
        check("stop_h_cnt", int'(bus.h_cnt), 0);
        check("stop_v_cnt", int'(bus.v_cnt), 0);
        pulse_stop();
        check("second_stop_busy", int'(busy), 0);
        check("second_stop_h_total", int'(bus.h_total), 8);

        // 8/4/2: ce every third cycle across two frames
        send_cfg(8, 4, 2);
        push_frame(8, 4, 0, 3);
        push_frame(8, 4, 3, 3);
        pulse_start();
        wait_hv(3, 1);
        wait_hv(0, 0);
        wait_hv(3, 1);
        pulse_stop();
        drain();
        check("div_stop_busy", int'(busy), 0);

        // Pending config 10/4/0 offered at v=1 of an 8/4/0 frame
        send_cfg(8, 4, 0);
        push_frame(8, 4, 0, 1);
        push_frame(10, 4, 1, 1);
        push_frame(10, 4, 1, 1);
        pulse_start();
        wait_hv(0, 1);
        send_cfg(10, 4, 0);
        n = 0;
        while (!bus.cfg_ready && n < 100) begin
            n++;
            tick();
        end
        check("pending_ready_low_cycles", n, 23);
        check("pending_h_total", int'(bus.h_total), 10);
        wait_hv(3, 1);
        wait_hv(0, 0);
        wait_hv(3, 1);
        send_cfg(6, 2, 1);
        pulse_stop();
        drain();
        check("pend_stop_busy", int'(busy), 0);
        check("pend_stop_h_total", int'(bus.h_total), 6);
        check("pend_stop_v_total", int'(bus.v_total), 2);

        // Next start runs the config that was pending at the stop
        push_frame(6, 2, 0, 2);
        pulse_start();
        wait_hv(1, 0);
        pulse_stop();
        drain();
        check("six_two_busy", int'(busy), 0);

        // Reset mid-RUN
        push_frame(6, 2, 0, 2);
        pulse_start();
        wait_hv(2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_busy", int'(busy), 0);
        check("midrst_ce", int'(bus.ce), 0);
        check("midrst_h_cnt", int'(bus.h_cnt), 0);
        check("midrst_v_cnt", int'(bus.v_cnt), 0);
        check("midrst_h_total", int'(bus.h_total), 0);
        check("midrst_frame_start", int'(bus.frame_start), 0);
        check("midrst_cfg_ready", int'(bus.cfg_ready), 1);
        pulse_start();
        check("midrst_start_ignored", int'(busy), 0);

        // Stop during ARM returns to IDLE
        send_cfg(8, 4, 0);
        pulse_start();
        check("arm_entry_busy", int'(busy), 1);
        pulse_stop();
        check("arm_stop_busy", int'(busy), 0);
        repeat (6) tick();
        check("arm_stop_no_ce_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bt1120_timing_ctrl.md
BT1120_TIMING_CTRL -- requirements
Module: bt1120_timing_ctrl

Interface
REQ-001 SHALL have parameter VH_BITWIDTH, default 13, width of all h/v counts and totals.
REQ-002 SHALL have parameter SETTLE, default 3, number of ARM cycles that let the downstream generator's registered compare points settle.
REQ-003 clk  in  1  sole clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request to begin frame generation.
REQ-006 stop  in  1  request to stop at the end of the current frame.
REQ-007 cfg_valid  in  1  new timing configuration offered.
REQ-008 cfg_ready  out  1  configuration can be accepted.
REQ-009 cfg_h_total, cfg_v_total  in  VH_BITWIDTH each  offered totals.
REQ-010 cfg_ce_div  in  4  offered clock-enable divisor.
REQ-011 h_total, v_total  out  VH_BITWIDTH each  active totals driven to the generator.
REQ-012 ce  out  1  pixel clock enable.
REQ-013 h_cnt, v_cnt  out  VH_BITWIDTH each  pixel/line counters.
REQ-014 frame_start  out  1  marks the first ce of a frame.
REQ-015 busy  out  1  high when the state is not IDLE.
REQ-016 cfg_err  out  1  one-cycle pulse when an invalid configuration is rejected.

Function
REQ-017 SHALL implement the states IDLE, ARM and RUN, plus a stop_req flag and a one-deep pending-config register.
REQ-018 Handshake: a transfer SHALL occur on cfg_valid && cfg_ready; cfg_ready SHALL be 1 in IDLE and ARM, and SHALL be !pending in RUN.
REQ-019 Validity: a config SHALL be valid iff cfg_h_total >= 2 and cfg_v_total >= 2; an invalid transfer SHALL be consumed, SHALL pulse cfg_err the next cycle, and SHALL leave active and pending unchanged.
REQ-020 In IDLE or ARM, a valid transfer SHALL update the active registers on the next cycle.
REQ-021 In RUN, a valid transfer SHALL load the pending register; pending SHALL be applied on the frame-end ce.
REQ-022 Transition IDLE->ARM SHALL occur on start && !stop && active h_total != 0; otherwise start SHALL be ignored.
REQ-023 In ARM, the block SHALL stay SETTLE cycles, then enter RUN; stop during ARM SHALL return the block to IDLE the next cycle.
REQ-024 Divider: div_cnt SHALL count 0..ce_div and wrap; ce SHALL equal (state==RUN && div_cnt==0), so ce_div=0 gives ce on every cycle of RUN.
REQ-025 Counters SHALL update only on a ce cycle: h_cnt increments and wraps from h_total-1 to 0; v_cnt increments on h wrap and wraps from v_total-1 to 0.
REQ-026 frame_start SHALL equal ce && h_cnt==0 && v_cnt==0.
REQ-027 Frame end SHALL be defined as ce && h_cnt==h_total-1 && v_cnt==v_total-1.
REQ-028 At frame end, the block SHALL apply pending if present (clear pending, reset div_cnt to 0); if stop_req is set, it SHALL go to IDLE.
REQ-029 stop SHALL set stop_req during RUN; stop_req SHALL be cleared on entry to IDLE; start during RUN SHALL be ignored.
REQ-030 In IDLE and ARM: ce=0, h_cnt=0, v_cnt=0, div_cnt=0.
REQ-031 A pending transfer and stop in the same frame SHALL both take effect at frame end, so the next start uses the new config.

Reset
REQ-032 On rst, the block SHALL enter IDLE with h_cnt=v_cnt=0, h_total=v_total=0, ce_div=0, pending=0, stop_req=0, and ce=frame_start=busy=cfg_err=0.
REQ-033 rst SHALL take effect immediately in any state, including mid-frame, and SHALL discard pending.

Verification
REQ-034 cfg 8/4/0, start pulse -> busy on the next cycle, 3 ARM cycles, then ce constant 1, h_cnt 0..7, v_cnt 0..3, frame_start every 32 cycles.
REQ-035 cfg 8/4/2 -> ce every 3rd cycle, counters step only on ce, frame_start every 96 cycles.
REQ-036 In RUN, cfg 10/4/0 at v_cnt=1 -> cfg_ready low until frame end; the following frame has h_cnt 0..9 and a frame_start period of 40.
REQ-037 stop at h_cnt=3, v_cnt=1 -> frame completes through h=7, v=3, then IDLE, busy=0, counters 0; a second stop changes nothing.
REQ-038 cfg 1/4/0 -> cfg_err pulse, active totals unchanged; cfg 0/0 from reset followed by start -> stays IDLE.
REQ-039 rst mid-RUN -> all outputs at reset values on the next cycle, and start is ignored until a new valid cfg is accepted.
